// File: rtl/eq_arb_pkg.sv
// Shared types and the round-robin search helper for the compare arbiter.
package eq_arb_pkg;

    localparam int unsigned NREQ_MAX = 16;
    localparam int unsigned PTRW     = 4;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    typedef struct packed {
        logic            found;
        logic [PTRW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input logic [PTRW-1:0]     ptr,
                                         input int unsigned         nreq);
        rr_pick_t    res;
        int unsigned idx;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned k = 0; k < NREQ_MAX; k++) begin
            if (k < nreq) begin
                idx = (32'(ptr) + k) % nreq;
                if (!res.found && valid[idx[PTRW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[PTRW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eq_unit.sv
// Combinational bitwise equality of two WIDTH-bit operands.
module eq_unit #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out
);

    assign out = (in0 == in1);

endmodule

// File: rtl/eq_compare_arbiter.sv
// Round-robin sharing of one equality comparator among NREQ requesters,
// with a one-deep registered result slot.
module eq_compare_arbiter
    import eq_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_eq,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    slot_state_e      r_state;
    logic             r_eq;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;

    rr_pick_t         w_pick;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_next_ptr;
    logic             w_slot_open;
    logic             w_fire;
    logic             w_eq;
    logic [WIDTH-1:0] w_a_lane [NREQ];
    logic [WIDTH-1:0] w_b_lane [NREQ];

    always_comb begin
        w_pick = rr_pick(NREQ_MAX'(req_valid), PTRW'(r_rr_ptr), NREQ);
    end

    assign w_grant    = w_pick.idx[IDW-1:0];
    assign w_next_ptr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    // Held in reset, the slot is not open so nothing can be readied.
    assign w_slot_open = ASYNCRESETN && ((r_state == SLOT_EMPTY) || rsp_ready);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = w_slot_open && w_pick.found && (w_pick.idx == PTRW'(i));
        end
    end

    assign w_fire = |req_ready;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_a_lane[i] = req_a[i*WIDTH +: WIDTH];
        assign w_b_lane[i] = req_b[i*WIDTH +: WIDTH];
    end

    eq_unit #(
        .WIDTH (WIDTH)
    ) u_eq_unit (
        .in0 (w_a_lane[w_grant]),
        .in1 (w_b_lane[w_grant]),
        .out (w_eq)
    );

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state  <= SLOT_EMPTY;
            r_eq     <= 1'b0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_fire) begin
                        r_state  <= SLOT_FULL;
                        r_eq     <= w_eq;
                        r_id     <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                SLOT_FULL: begin
                    if (w_fire) begin
                        r_eq     <= w_eq;
                        r_id     <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                    end else if (rsp_ready) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    assign rsp_valid = (r_state == SLOT_FULL);
    assign rsp_eq    = r_eq;
    assign rsp_id    = r_id;
    assign busy      = rsp_valid || (|req_valid);

endmodule

// File: doc/eq_compare_arbiter.md
Name: eq_compare_arbiter

Overview:
- Shares one WIDTH-bit equality comparator among NREQ requesters.
- Each requester offers an operand pair over a valid/ready handshake. A round-robin arbiter grants one pair per cycle to the comparator.
- The 1-bit result and the requester ID are registered into a one-deep output slot with its own valid/ready handshake.
- Sits between the per-lane compare clients (SInt/Bits eq users) and the single shared comparator instance.

Parameters:
- WIDTH, 3, operand width in bits; equality is bitwise, so signedness is irrelevant.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), width of requester ID; derived, not overridable.

Ports:
- CLK  in  1  clock, rising edge
- ASYNCRESETN  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand pair valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- rsp_valid  out  1  result slot occupied
- rsp_ready  in  1  consumer accepts result
- rsp_eq  out  1  1 when A == B for the granted pair
- rsp_id  out  IDW  index of the requester the result belongs to
- busy  out  1  high when rsp_valid is high or any req_valid is high (status only)

Behaviour:
- Reset: while ASYNCRESETN = 0, asynchronously clear rsp_valid=0, rsp_eq=0, rsp_id=0 and rr_ptr=0. req_ready=0 because the slot is not yet open.
- A reset asserted mid-operation discards any held result. No partial transfer is visible after release.
- Slot FSM has two states:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- slot_open = EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill allowed; full throughput of 1 compare per cycle).
- Arbitration is combinational and round-robin.
  - Search req_valid starting at index rr_ptr, ascending, wrapping NREQ-1 -> 0.
  - The first set bit is grant g.
  - req_ready[g] = slot_open and any req_valid. All other req_ready bits are 0.
  - req_ready never depends on req_valid of the same requester beyond selection. No requester is readied without being valid.
- Transfer: req_valid[g] and req_ready[g] high at a clock edge cause:
  - rsp_eq <= (req_a[g] == req_b[g]) from the eq_unit
  - rsp_id <= g
  - rsp_valid <= 1
  - rr_ptr <= (g+1) mod NREQ
- Drain without refill: rsp_ready=1 in FULL with no request -> rsp_valid <= 0. rsp_eq and rsp_id hold their last value.
- Stall: in FULL with rsp_ready=0:
  - rsp_eq, rsp_id and rsp_valid are stable.
  - All req_ready bits are 0.
- rr_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Latency: the result appears on rsp_* the cycle after the request handshake, i.e. 1 cycle.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Requesters may drop req_valid without a handshake. The arbiter treats this as withdrawal; no state is kept.
- Operand width rule: the comparison is over exactly WIDTH bits with no sign extension. For WIDTH=3, 3'b111 == 3'b111, i.e. -1 == -1 as SInt.

Decomposition:
- Shared package eq_arb_pkg holds:
  - the slot state enum {SLOT_EMPTY, SLOT_FULL}
  - the function rr_pick(valid, ptr) returning the grant index and a found flag
  - a localparam for the NREQ upper bound (16)
- Sub-module eq_unit (parameter width): combinational compare with ports in0, in1, out.
  - Instantiated once.
  - Fed by a NREQ:1 mux of req_a/req_b selected by g.
- Remaining logic lives in eq_compare_arbiter: arbiter, slot register, rr_ptr.

Test Plan:
- Reset/idle:
  - Stimulus: ASYNCRESETN low mid-cycle with a result held (rsp_valid=1).
  - Required: rsp_valid, rsp_eq and rsp_id drop to 0 immediately (no clock edge needed); req_ready=0 during reset.
  - After release with no requests: everything stays 0.
- Single compare:
  - Stimulus: requester 2 presents a=3'b101, b=3'b101.
  - Required: req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_eq=1, rsp_id=2.
  - Repeat with b=3'b100: rsp_eq=0.
- Round-robin:
  - Stimulus: all four req_valid held high, rsp_ready=1.
  - Required: grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0, one per cycle with no bubbles.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after the first result.
  - Required: req_ready=0 throughout; rsp_eq/rsp_id unchanged.
  - rsp_ready=1 then gives a same-cycle drain and refill with the next requester's result on the following cycle.
- Wrap and skip:
  - Stimulus: rr_ptr=3, req_valid=4'b0010.
  - Required: grant 1, then rr_ptr=2.
  - Next, with req_valid=4'b1001: grant 3, then rr_ptr=0.
- Signed boundary:
  - Stimulus: a=3'b100 (-4), b=3'b100 -> rsp_eq=1.
  - Stimulus: a=3'b100, b=3'b000 -> rsp_eq=0.
  - Stimulus: a=3'b111, b=3'b011 -> rsp_eq=0.
